// File: rtl/conv_window_gen.sv
// conv_window_gen: line-buffered sliding-window generator for a streaming conv layer.
// Takes an IN_DIM x IN_DIM raster pixel stream and emits every valid K_DIM x K_DIM
// window, tagged with its output coordinate, one window per output handshake.
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   s_valid/s_ready   input pixel handshake; s_ready = !m_valid || m_ready
//   s_data            signed pixel, raster order (row-major, column fastest)
//   m_valid/m_ready   window handshake
//   m_window          element (k,l) at [(k*K_DIM+l)*DATA_W +: DATA_W]
//   m_row, m_col      top-left input coordinate of the window
//   m_last            marks the final window of the frame
//   frame_done        one-cycle pulse the cycle after the final window is accepted
module conv_window_gen #(
    parameter int unsigned IN_DIM = 28,
    parameter int unsigned K_DIM  = 5,
    parameter int unsigned DATA_W = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [DATA_W-1:0]             s_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [K_DIM*K_DIM*DATA_W-1:0] m_window,
    output logic [$clog2(IN_DIM)-1:0]     m_row,
    output logic [$clog2(IN_DIM)-1:0]     m_col,
    output logic                          m_last,
    output logic                          frame_done
);

    localparam int unsigned CW    = $clog2(IN_DIM);
    localparam int unsigned WIN_W = K_DIM * K_DIM * DATA_W;
    localparam logic [CW-1:0] LAST_IDX = CW'(IN_DIM - 1);
    localparam logic [CW-1:0] EDGE_IDX = CW'(K_DIM - 1);

    // Position of the next pixel to be accepted
    logic [CW-1:0]     r_in_row;
    logic [CW-1:0]     r_in_col;

    // Previous K_DIM-1 rows; r_lb[0] is the oldest row, r_lb[K_DIM-2] the newest
    logic [DATA_W-1:0] r_lb  [K_DIM-1][IN_DIM];
    // Sliding window; column K_DIM-1 holds the most recently accepted column
    logic [DATA_W-1:0] r_win [K_DIM][K_DIM];

    logic              r_m_valid;
    logic [WIN_W-1:0]  r_m_window;
    logic [CW-1:0]     r_m_row;
    logic [CW-1:0]     r_m_col;
    logic              r_m_last;
    logic              r_frame_done;

    logic              w_s_acc;
    logic              w_m_acc;
    logic              w_produce;
    logic              w_frame_end;
    logic [DATA_W-1:0] w_col     [K_DIM];
    logic [DATA_W-1:0] w_win_nxt [K_DIM][K_DIM];
    logic [WIN_W-1:0]  w_win_flat;

    assign s_ready    = !r_m_valid || m_ready;
    assign w_s_acc    = s_valid && s_ready;
    assign w_m_acc    = r_m_valid && m_ready;
    // Only pixels at or beyond the kernel edge in both dimensions complete a window
    assign w_produce  = w_s_acc && (r_in_row >= EDGE_IDX) && (r_in_col >= EDGE_IDX);
    assign w_frame_end = (r_in_row == LAST_IDX) && (r_in_col == LAST_IDX);

    assign m_valid    = r_m_valid;
    assign m_window   = r_m_window;
    assign m_row      = r_m_row;
    assign m_col      = r_m_col;
    assign m_last     = r_m_last;
    assign frame_done = r_frame_done;

    // Window as it will look after the current pixel's column is shifted in
    always_comb begin
        w_win_flat = '0;
        for (int k = 0; k < int'(K_DIM); k++) begin
            if (k == int'(K_DIM) - 1) begin
                w_col[k] = s_data;
            end else begin
                w_col[k] = r_lb[k][r_in_col];
            end
        end
        for (int k = 0; k < int'(K_DIM); k++) begin
            for (int l = 0; l < int'(K_DIM) - 1; l++) begin
                w_win_nxt[k][l] = r_win[k][l+1];
            end
            w_win_nxt[k][K_DIM-1] = w_col[k];
        end
        for (int k = 0; k < int'(K_DIM); k++) begin
            for (int l = 0; l < int'(K_DIM); l++) begin
                w_win_flat[(k*int'(K_DIM)+l)*int'(DATA_W) +: DATA_W] = w_win_nxt[k][l];
            end
        end
    end

    // Line buffer column shift and window shift; contents are only ever read once valid
    always_ff @(posedge clk) begin
        if (w_s_acc) begin
            for (int j = 0; j < int'(K_DIM) - 2; j++) begin
                r_lb[j][r_in_col] <= r_lb[j+1][r_in_col];
            end
            r_lb[K_DIM-2][r_in_col] <= s_data;
            r_win <= w_win_nxt;
        end
    end

    // Raster position counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_in_row <= '0;
            r_in_col <= '0;
        end else if (w_s_acc) begin
            if (r_in_col == LAST_IDX) begin
                r_in_col <= '0;
                r_in_row <= (r_in_row == LAST_IDX) ? '0 : r_in_row + CW'(1);
            end else begin
                r_in_col <= r_in_col + CW'(1);
            end
        end
    end

    // Output register: reload on a producing pixel, otherwise drain on accept
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_m_valid    <= 1'b0;
            r_m_window   <= '0;
            r_m_row      <= '0;
            r_m_col      <= '0;
            r_m_last     <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_m_acc && r_m_last;
            if (w_produce) begin
                r_m_valid  <= 1'b1;
                r_m_window <= w_win_flat;
                r_m_row    <= r_in_row - EDGE_IDX;
                r_m_col    <= r_in_col - EDGE_IDX;
                r_m_last   <= w_frame_end;
            end else if (w_m_acc) begin
                r_m_valid  <= 1'b0;
                r_m_last   <= 1'b0;
            end
        end
    end

endmodule
